// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural program counter with next-PC selection,
// stall hold and a circular return-address stack for call/return.
// Redirect priority: return (non-empty RAS) > jump > taken branch > sequential.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter int              IMM_W     = 16,
    parameter int              JIMM_W    = 26,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              PC_STEP   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [IMM_W-1:0]             imm_16,
    input  logic [JIMM_W-1:0]            imm_26,
    input  logic                         zero,
    input  logic                         jump,
    input  logic                         link,
    input  logic                         ret,
    input  logic                         branch_eq,
    input  logic                         branch_ne,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              pc_plus_step,
    output logic                         pc_src,
    output logic [XLEN-1:0]              target_address,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [XLEN-1:0]  STEP     = XLEN'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // Architectural state
    logic [XLEN-1:0]  pc_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Return-address storage (contents need no reset)
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;

    // Datapath intermediates
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  branch_off;
    logic [XLEN-1:0]  branch_tgt;
    logic [XLEN-1:0]  jump_tgt;
    logic [XLEN-1:0]  ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ret_hit;
    logic             branch_taken;
    logic [XLEN-1:0]  next_pc;
    logic             redirect;

    // Event qualifiers for this edge
    logic             do_push;
    logic             do_pop;
    logic             do_unf;

    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return p - PTR_W'(1);
    endfunction

    // Word-offset immediate: sign-extend, then scale to bytes.
    function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

    // Jump keeps the current region bits above the word-index field.
    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0]   cur,
                                                    input logic [JIMM_W-1:0] idx);
        return {cur[XLEN-1:JIMM_W+2], idx, 2'b00};
    endfunction

    assign seq_pc     = pc_q + STEP;
    assign branch_off = branch_offset(imm_16);
    assign branch_tgt = pc_q + branch_off;
    assign jump_tgt   = jump_target(pc_q, imm_26);

    // ptr_q points at the next free slot, so the top lives one below it.
    assign ras_top    = ras_q[ptr_dec(ptr_q)];
    assign ras_empty  = (cnt_q == '0);
    assign ras_full   = (cnt_q == CNT_FULL);

    assign ret_hit      = ret & ~ras_empty;
    assign branch_taken = (branch_eq & zero) | (branch_ne & ~zero);

    // Next-PC selection; evaluated every cycle, stalled or not.
    always_comb begin
        next_pc  = seq_pc;
        redirect = 1'b0;
        if (ret_hit) begin
            next_pc  = ras_top;
            redirect = 1'b1;
        end else if (jump) begin
            next_pc  = jump_tgt;
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = branch_tgt;
            redirect = 1'b1;
        end
    end

    assign do_push = jump & link & ~stall;
    assign do_pop  = ret & ~stall & ~ras_empty;
    assign do_unf  = ret & ~stall & ras_empty;

    // RAS pointer/count/event next-state; a stall suppresses every update.
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        unf_d     = do_unf;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (do_pop && do_push) begin
            // Pop then push in one edge: the top entry is replaced in place,
            // depth is unchanged and the stack never overflows.
            ras_we    = 1'b1;
            ras_waddr = ptr_dec(ptr_q);
        end else if (do_push) begin
            // A push into a full stack lands on the oldest slot.
            ras_we    = 1'b1;
            ras_waddr = ptr_q;
            ptr_d     = ptr_inc(ptr_q);
            if (ras_full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_d = ptr_dec(ptr_q);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control registers: PC, RAS pointer/count and the one-cycle event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (!stall) begin
                pc_q <= next_pc;
            end
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address write port; the pushed value is always the caller's pc + step.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_q[ras_waddr] <= seq_pc;
        end
    end

    assign pc             = pc_q;
    assign pc_plus_step   = seq_pc;
    assign pc_src         = redirect;
    assign target_address = next_pc;
    assign ras_count      = cnt_q;
    assign ras_overflow   = ovf_q;
    assign ras_underflow  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential flow, branches,
// call/return, RAS overflow/underflow, stall hold, combined ret+call, async reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [15:0] imm_16;
    logic [25:0] imm_26;
    logic        zero, jump, link, ret, branch_eq, branch_ne;

    logic [31:0] pc, pc_plus_step, target_address;
    logic        pc_src, ras_overflow, ras_underflow;
    logic [3:0]  ras_count;

    logic [31:0] h_pc, h_pps, h_tgt;
    logic        h_src, h_ovf, h_unf;
    logic [3:0]  h_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imm_16(imm_16), .imm_26(imm_26),
        .zero(zero), .jump(jump), .link(link), .ret(ret),
        .branch_eq(branch_eq), .branch_ne(branch_ne),
        .pc(pc), .pc_plus_step(pc_plus_step), .pc_src(pc_src),
        .target_address(target_address), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    pc_sequencer #(.RESET_PC(32'h4000_0010)) dut_hi (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imm_16(imm_16), .imm_26(imm_26),
        .zero(zero), .jump(jump), .link(link), .ret(ret),
        .branch_eq(branch_eq), .branch_ne(branch_ne),
        .pc(h_pc), .pc_plus_step(h_pps), .pc_src(h_src),
        .target_address(h_tgt), .ras_count(h_cnt),
        .ras_overflow(h_ovf), .ras_underflow(h_unf)
    );

    task automatic clear_ctl();
        stall = 0; imm_16 = '0; imm_26 = '0; zero = 0;
        jump = 0; link = 0; ret = 0; branch_eq = 0; branch_ne = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_ctl();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_ctl();
        rst_n = 1'b0;
        tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        n_vec++; if (ras_count !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", ras_count); end
        n_vec++; if ({ras_overflow, ras_underflow} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {ras_overflow, ras_underflow}); end
        n_vec++; if (pc_plus_step !== 32'h4) begin n_err++; $display("FAIL rst_pps: got %h want %h", pc_plus_step, 32'h4); end
        n_vec++; if (target_address !== 32'h4) begin n_err++; $display("FAIL rst_tgt: got %h want %h", target_address, 32'h4); end
        n_vec++; if (h_pc !== 32'h4000_0010) begin n_err++; $display("FAIL rst_hi_pc: got %h want %h", h_pc, 32'h4000_0010); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            n_vec++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL seq_src%0d: got %b want 0", i, pc_src); end
            tick();
            exp = 32'(i * 4);
            n_vec++; if (pc !== exp) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp); end
        end
    endtask

    task automatic test_branch();
        do_reset();
        jump = 1; imm_26 = 26'h40; #1;
        n_vec++; if (target_address !== 32'h100) begin n_err++; $display("FAIL j100_tgt: got %h want %h", target_address, 32'h100); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL j100_pc: got %h want %h", pc, 32'h100); end
        // taken backward branch: 0x100 + (-4 << 2)
        branch_eq = 1; zero = 1; imm_16 = 16'hFFFC; #1;
        n_vec++; if (target_address !== 32'hF0) begin n_err++; $display("FAIL beq_tgt: got %h want %h", target_address, 32'hF0); end
        n_vec++; if (pc_src !== 1'b1) begin n_err++; $display("FAIL beq_src: got %b want 1", pc_src); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'hF0) begin n_err++; $display("FAIL beq_pc: got %h want %h", pc, 32'hF0); end
        jump = 1; imm_26 = 26'h40;
        tick(); clear_ctl();
        // beq not taken when zero is low
        branch_eq = 1; zero = 0; imm_16 = 16'hFFFC; #1;
        n_vec++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL beqnt_src: got %b want 0", pc_src); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h104) begin n_err++; $display("FAIL beqnt_pc: got %h want %h", pc, 32'h104); end
        // bne taken forward: 0x104 + 12
        branch_ne = 1; zero = 0; imm_16 = 16'h0003;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h110) begin n_err++; $display("FAIL bne_pc: got %h want %h", pc, 32'h110); end
        // wrap below zero, then sequential wrap back to zero
        do_reset();
        branch_ne = 1; zero = 0; imm_16 = 16'hFFFF;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL bwrap_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
        n_vec++; if (pc_plus_step !== 32'h0) begin n_err++; $display("FAIL bwrap_pps: got %h want %h", pc_plus_step, 32'h0); end
        tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL swrap_pc: got %h want %h", pc, 32'h0); end
    endtask

    task automatic test_call_return();
        do_reset();
        jump = 1; link = 1; imm_26 = 26'h40;
        tick(); clear_ctl();
        n_vec++; if (h_pc !== 32'h4000_0100) begin n_err++; $display("FAIL call_pc: got %h want %h", h_pc, 32'h4000_0100); end
        n_vec++; if (h_cnt !== 4'd1) begin n_err++; $display("FAIL call_cnt: got %0d want 1", h_cnt); end
        ret = 1; #1;
        n_vec++; if (h_tgt !== 32'h4000_0014) begin n_err++; $display("FAIL ret_tgt: got %h want %h", h_tgt, 32'h4000_0014); end
        n_vec++; if (h_src !== 1'b1) begin n_err++; $display("FAIL ret_src: got %b want 1", h_src); end
        tick(); clear_ctl();
        n_vec++; if (h_pc !== 32'h4000_0014) begin n_err++; $display("FAIL ret_pc: got %h want %h", h_pc, 32'h4000_0014); end
        n_vec++; if (h_cnt !== 4'd0) begin n_err++; $display("FAIL ret_cnt: got %0d want 0", h_cnt); end
    endtask

    task automatic test_ras_limits();
        logic [31:0] exp;
        logic [3:0]  ecnt;
        do_reset();
        // call k at pc 0x40*(k-1) jumps to 0x40*k and pushes 0x40*(k-1)+4
        for (int k = 1; k <= 9; k++) begin
            jump = 1; link = 1; imm_26 = 26'(k * 16);
            tick();
            ecnt = (k > 8) ? 4'd8 : 4'(k);
            n_vec++; if (ras_count !== ecnt) begin n_err++; $display("FAIL ovf_cnt%0d: got %0d want %0d", k, ras_count, ecnt); end
            n_vec++; if (ras_overflow !== (k == 9)) begin n_err++; $display("FAIL ovf_flag%0d: got %b want %b", k, ras_overflow, (k == 9)); end
        end
        clear_ctl();
        // pops return 0x204, 0x1C4, ..., 0x44; the first return address was overwritten
        for (int i = 0; i < 8; i++) begin
            ret = 1; #1;
            exp = 32'((9 - i - 1) * 64 + 4);
            n_vec++; if (target_address !== exp) begin n_err++; $display("FAIL pop_tgt%0d: got %h want %h", i, target_address, exp); end
            tick();
            n_vec++; if (pc !== exp || ras_count !== 4'(7 - i)) begin n_err++; $display("FAIL pop_pc%0d: got %h/%0d want %h/%0d", i, pc, ras_count, exp, 7 - i); end
        end
        ret = 1; #1;
        n_vec++; if (pc_src !== 1'b0 || target_address !== 32'h48) begin n_err++; $display("FAIL unf_tgt: got %b/%h want 0/%h", pc_src, target_address, 32'h48); end
        tick(); clear_ctl();
        n_vec++; if (ras_underflow !== 1'b1 || pc !== 32'h48) begin n_err++; $display("FAIL unf_pulse: got %b/%h want 1/%h", ras_underflow, pc, 32'h48); end
        n_vec++; if (ras_count !== 4'd0) begin n_err++; $display("FAIL unf_cnt: got %0d want 0", ras_count); end
        tick();
        n_vec++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr: got %b want 0", ras_underflow); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1; jump = 1; link = 1; imm_26 = 26'h20; #1;
        n_vec++; if (target_address !== 32'h80 || pc_src !== 1'b1) begin n_err++; $display("FAIL stl_tgt: got %h/%b want %h/1", target_address, pc_src, 32'h80); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 32'h0 || ras_count !== 4'd0) begin n_err++; $display("FAIL stl_hold%0d: got %h/%0d want 0/0", i, pc, ras_count); end
        end
        stall = 0;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h80 || ras_count !== 4'd1) begin n_err++; $display("FAIL stl_rel: got %h/%0d want %h/1", pc, ras_count, 32'h80); end
        tick();
        n_vec++; if (pc !== 32'h84 || ras_count !== 4'd1) begin n_err++; $display("FAIL stl_once: got %h/%0d want %h/1", pc, ras_count, 32'h84); end
        ret = 1; #1;
        n_vec++; if (target_address !== 32'h4) begin n_err++; $display("FAIL stl_ret: got %h want %h", target_address, 32'h4); end
        clear_ctl();
    endtask

    task automatic test_back_to_back();
        do_reset();
        jump = 1; link = 1; imm_26 = 26'h10;
        tick();
        // ret + call on a non-empty stack: redirect to old top, top replaced
        ret = 1; imm_26 = 26'h30; #1;
        n_vec++; if (target_address !== 32'h4) begin n_err++; $display("FAIL rjl_tgt: got %h want %h", target_address, 32'h4); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h4 || ras_count !== 4'd1 || ras_overflow !== 1'b0) begin n_err++; $display("FAIL rjl_state: got %h/%0d/%b want %h/1/0", pc, ras_count, ras_overflow, 32'h4); end
        ret = 1; #1;
        n_vec++; if (target_address !== 32'h44) begin n_err++; $display("FAIL rjl_newtop: got %h want %h", target_address, 32'h44); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h44 || ras_count !== 4'd0) begin n_err++; $display("FAIL rjl_pop: got %h/%0d want %h/0", pc, ras_count, 32'h44); end
        // ret + call on an empty stack: underflow, jump taken, push performed
        ret = 1; jump = 1; link = 1; imm_26 = 26'h20; #1;
        n_vec++; if (target_address !== 32'h80) begin n_err++; $display("FAIL erjl_tgt: got %h want %h", target_address, 32'h80); end
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h80 || ras_count !== 4'd1 || ras_underflow !== 1'b1) begin n_err++; $display("FAIL erjl_state: got %h/%0d/%b want %h/1/1", pc, ras_count, ras_underflow, 32'h80); end
        ret = 1;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h48 || ras_count !== 4'd0 || ras_underflow !== 1'b0) begin n_err++; $display("FAIL erjl_ret: got %h/%0d/%b want %h/0/0", pc, ras_count, ras_underflow, 32'h48); end
        // link without jump is ignored
        link = 1;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h4C || ras_count !== 4'd0) begin n_err++; $display("FAIL link_only: got %h/%0d want %h/0", pc, ras_count, 32'h4C); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tick();
        jump = 1; link = 1; imm_26 = 26'h10;
        tick(); clear_ctl();
        n_vec++; if (pc !== 32'h40 || ras_count !== 4'd1) begin n_err++; $display("FAIL ar_pre: got %h/%0d want %h/1", pc, ras_count, 32'h40); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (pc !== 32'h0 || ras_count !== 4'd0) begin n_err++; $display("FAIL ar_clear: got %h/%0d want 0/0", pc, ras_count); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL ar_first: got %h want %h", pc, 32'h4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_ctl();
        rst_n = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_call_return();
        test_ras_limits();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the single-cycle/multicycle core. It combines next-PC selection with the architectural PC register, a stall hold, and a return-address stack (RAS) for call/return.
- It selects among sequential, conditional-branch, absolute-jump and return targets, then registers the result as the new PC each un-stalled cycle.
- It sits between the instruction memory address port and the decode/ALU control outputs.

Parameters:
- XLEN, 32, PC/address width; must be >= JIMM_W+2.
- IMM_W, 16, branch offset immediate width (word offset).
- JIMM_W, 26, jump immediate width (word index).
- RAS_DEPTH, 8, return-address stack entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC and RAS this cycle
- imm_16  in  IMM_W  branch word offset, signed
- imm_26  in  JIMM_W  jump word index
- zero  in  1  ALU zero flag
- jump  in  1  absolute jump
- link  in  1  with jump: push return address (call)
- ret  in  1  return: pop RAS
- branch_eq  in  1  branch if zero
- branch_ne  in  1  branch if !zero
- pc  out  XLEN  current PC (registered)
- pc_plus_step  out  XLEN  pc + PC_STEP (combinational)
- pc_src  out  1  1 = non-sequential redirect taken this cycle
- target_address  out  XLEN  next PC value (combinational)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  out  1  one-cycle pulse: push into full RAS
- ras_underflow  out  1  one-cycle pulse: pop from empty RAS

Behaviour:
- Reset (rst_n low, async): pc = RESET_PC, ras_count = 0, RAS pointer = 0, ras_overflow = ras_underflow = 0. RAS contents are don't-care. Combinational outputs follow from the reset pc.
- Branch target: pc + (sign_extend(imm_16) << 2), computed modulo 2^XLEN; no overflow detection.
- Jump target: {pc[XLEN-1:JIMM_W+2], imm_26, 2'b00}.
- Sequential: pc + PC_STEP, wrapping at 2^XLEN.
- Selection priority (combinational, evaluated every cycle including stalled cycles):
  1. ret with ras_count > 0 -> RAS top, pc_src = 1.
  2. jump -> jump target, pc_src = 1.
  3. (branch_eq & zero) | (branch_ne & !zero) -> branch target, pc_src = 1.
  4. Otherwise -> sequential, pc_src = 0.
  - ret with empty RAS falls through to priorities 2-4.
- target_address always equals the selected next PC. It is never forced to 0.
- Clock edge with stall = 0: pc <= target_address, and RAS updates apply.
- Clock edge with stall = 1: pc, RAS, ras_count unchanged; ras_overflow/ras_underflow <= 0. No events are lost or queued.
- RAS, circular buffer with top pointer:
  - Push (jump & link & !stall): store pc + PC_STEP, pointer +1 mod RAS_DEPTH. ras_count increments, saturating at RAS_DEPTH.
  - Push when full: overwrites the oldest entry; ras_count stays at RAS_DEPTH; ras_overflow pulses 1 for one cycle.
  - Pop (ret & !stall & ras_count > 0): pointer -1, ras_count -1.
  - Pop when empty: no state change; ras_underflow pulses 1 for one cycle.
- Simultaneous ret & jump & link with non-empty RAS: pop then push in the same edge.
  - Net ras_count unchanged.
  - Top is replaced with pc + PC_STEP.
  - Redirect target is the old top (ret priority).
  - ras_overflow is not asserted in this case.
- Simultaneous ret & jump & link with empty RAS: underflow pulse, jump taken, push performed (count 0 -> 1).
- link without jump: ignored.
- Latency: the redirect is visible on pc one cycle after the control inputs are sampled. pc_src and target_address are same-cycle combinational.
- Reset asserted mid-operation: state clears immediately, independent of clk. The first post-reset edge loads RESET_PC + PC_STEP (or the selected target).

Test Plan:
- Reset, then 3 edges with no controls -> pc = 0x0, 0x4, 0x8, 0xC; pc_src = 0 throughout.
- pc = 0x100, branch_eq = 1, zero = 1, imm_16 = 0xFFFC -> target_address = 0xF0, pc_src = 1, pc = 0xF0 next cycle. Same with zero = 0 -> pc = 0x104.
- pc = 0x4000_0010, jump = 1, link = 1, imm_26 = 0x40 -> pc = 0x4000_0100, ras_count = 1. Then ret = 1 -> pc = 0x4000_0014, ras_count = 0.
- 9 consecutive calls with RAS_DEPTH = 8 -> ras_overflow pulses on the 9th only, ras_count = 8. 8 returns pop the last 8 return addresses in LIFO order; a 9th ret -> ras_underflow pulse, pc sequential.
- stall = 1 held 3 cycles during jump & link -> pc and ras_count frozen; after release, one push and one redirect occur.
- Assert rst_n low between edges mid-sequence -> pc = RESET_PC and ras_count = 0 immediately, before the next clk edge.
